data_memory_ctrl: RTL

- Parametrised byte-addressed, big-endian data memory for the MIPS datapath.
- Replaces the fixed word/byte memory with a valid/ready request port and a one-cycle response pulse.
- Supports byte, halfword and word access, with signed or unsigned load extension.
- Adds alignment and range error reporting and configurable wait states to model slow memory.

---
 rtl/data_memory_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
//   Byte-addressed, big-endian data memory for the MIPS datapath. Requests
//   arrive on a valid/ready port, are captured on the accept edge, optionally
//   delayed by WAIT_STATES cycles, and answered with a one-cycle response.
//   Byte, halfword and word accesses are supported, with signed or unsigned
//   load extension, plus alignment and address-range error reporting.
//
// Ports:
//   clock_i       system clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   request can be accepted this cycle
//   req_write_i   1 = store, 0 = load
//   req_size_i    00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_signed_i  loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr_i    byte address
//   req_wdata_i   store data, right-justified
//   resp_valid_o  one-cycle response pulse
//   resp_rdata_o  load result (0 for stores and errors), held between pulses
//   resp_error_o  request rejected, held between pulses
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int          DEPTH_BYTES = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o
);

    localparam int          IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [32:0] DEPTH33   = 33'(DEPTH_BYTES);
    localparam logic [32:0] BASE33    = {1'b0, BASE_ADDR};
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        valid_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        error_q;

    logic [7:0]  mem [DEPTH_BYTES];

    logic        accept;
    logic        commit;
    logic [32:0] offset;
    logic [32:0] endOffset;
    logic [32:0] sizeBytes;
    logic        misaligned;
    logic        outOfRange;
    logic        accessErr;
    logic [IDX_W-1:0] off0, off1, off2, off3;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] loadData;
    logic [31:0] rdataNow;

    assign accept = req_valid_i && ready_q;

    // The offset and end-of-access are kept in 33 bits so an access that
    // runs past 32'hFFFF_FFFF cannot wrap back into the valid window.
    assign offset     = {1'b0, addr_q} - BASE33;
    assign endOffset  = offset + sizeBytes;
    assign outOfRange = (addr_q < BASE_ADDR) || (endOffset > DEPTH33);
    assign accessErr  = misaligned || outOfRange;

    assign off0 = offset[IDX_W-1:0];
    assign off1 = off0 + IDX_W'(1);
    assign off2 = off0 + IDX_W'(2);
    assign off3 = off0 + IDX_W'(3);

    assign b0 = mem[off0];
    assign b1 = mem[off1];
    assign b2 = mem[off2];
    assign b3 = mem[off3];

    // Access width and alignment check for the captured request; the
    // reserved size code is reported through the same misaligned flag.
    always_comb begin
        sizeBytes  = 33'd1;
        misaligned = 1'b0;
        case (size_q)
            2'b00: sizeBytes = 33'd1;
            2'b01: begin
                sizeBytes  = 33'd2;
                misaligned = addr_q[0];
            end
            2'b10: begin
                sizeBytes  = 33'd4;
                misaligned = |addr_q[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Load data is read straight from the array during RESP, so a load that
    // follows a store back-to-back sees the bytes committed the edge before.
    always_comb begin
        loadData = '0;
        case (size_q)
            2'b00:   loadData = {{24{signed_q & b0[7]}}, b0};
            2'b01:   loadData = {{16{signed_q & b0[7]}}, b0, b1};
            2'b10:   loadData = {b0, b1, b2, b3};
            default: loadData = '0;
        endcase
        rdataNow = (write_q || accessErr) ? 32'd0 : loadData;
    end

    assign commit       = (state_q == S_RESP) && write_q && !accessErr;
    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign resp_rdata_o = valid_q ? rdataNow  : rdata_q;
    assign resp_error_o = valid_q ? accessErr : error_q;

    // Request FSM: captures the request on accept, counts wait states and
    // produces registered ready/valid. The response values are latched at the
    // end of RESP so the outputs hold them until the next pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            if (state_q == S_RESP) begin
                rdata_q <= rdataNow;
                error_q <= accessErr;
            end
            if (accept) begin
                write_q  <= req_write_i;
                size_q   <= req_size_i;
                signed_q <= req_signed_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
            end
            case (state_q)
                S_IDLE, S_RESP: begin
                    if (accept && HAS_WAIT) begin
                        state_q <= S_WAIT;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        cnt_q   <= WAIT_LOAD;
                    end else if (accept) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Store commit on the edge that ends RESP; only addressed bytes change.
    // The array has no reset, and a reset before RESP means no commit.
    always_ff @(posedge clock_i) begin
        if (commit) begin
            case (size_q)
                2'b00: mem[off0] <= wdata_q[7:0];
                2'b01: begin
                    mem[off0] <= wdata_q[15:8];
                    mem[off1] <= wdata_q[7:0];
                end
                2'b10: begin
                    mem[off0] <= wdata_q[31:24];
                    mem[off1] <= wdata_q[23:16];
                    mem[off2] <= wdata_q[15:8];
                    mem[off3] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule
